// File: rtl/run_detector.sv
`default_nettype none
// ============================================================================
// run_detector : flags when the last RUN_LEN enabled samples of w are equal,
//                with polarity / overlap modes and a saturating match counter.
// Revision     : 1.0 - initial release
// ============================================================================
module run_detector #(
   parameter int RUN_LEN = 2,
   parameter int CNT_W   = 8,
   parameter int ST_W    = $clog2(RUN_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             w,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             clr,
   output logic             z,
   output logic             last_w,
   output logic [ST_W-1:0]  run_len,
   output logic [CNT_W-1:0] match_count
);

   localparam logic [ST_W-1:0]  c_RUN_MAX = ST_W'(RUN_LEN);
   localparam logic [ST_W-1:0]  c_RUN_ONE = ST_W'(1);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

   logic [ST_W-1:0]  run_len_q, run_len_d;
   logic             last_w_q, last_w_d;
   logic [CNT_W-1:0] match_count_q, match_count_d;
   logic             w_hit;

   function automatic logic polarity_ok(input logic [1:0] m, input logic v);
      case (m)
         2'b01:   polarity_ok = v;
         2'b10:   polarity_ok = ~v;
         default: polarity_ok = 1'b1;
      endcase
   endfunction

   always_comb begin
      run_len_d = run_len_q;
      last_w_d  = last_w_q;
      if (en) begin
         if (run_len_q == '0 || w != last_w_q) begin
            run_len_d = c_RUN_ONE;
            last_w_d  = w;
         end else if (run_len_q < c_RUN_MAX) begin
            run_len_d = run_len_q + c_RUN_ONE;
         end else if (mode == 2'b11) begin
            // non-overlapping: a completed run starts counting afresh
            run_len_d = c_RUN_ONE;
         end
      end
   end

   // the counter looks at the next state so it moves on the same edge as z
   assign w_hit = en && (run_len_d == c_RUN_MAX) && polarity_ok(mode, last_w_d);

   always_comb begin
      match_count_d = match_count_q;
      if (clr) begin
         match_count_d = '0;
      end else if (w_hit && match_count_q != c_CNT_MAX) begin
         match_count_d = match_count_q + c_CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_len_q     <= '0;
         last_w_q      <= 1'b0;
         match_count_q <= '0;
      end else begin
         run_len_q     <= run_len_d;
         last_w_q      <= last_w_d;
         match_count_q <= match_count_d;
      end
   end

   assign z           = (run_len_q == c_RUN_MAX) && polarity_ok(mode, last_w_q);
   assign last_w      = last_w_q;
   assign run_len     = run_len_q;
   assign match_count = match_count_q;

endmodule
`default_nettype wire

// File: tb/tb_run_detector.sv
`default_nettype none
// ============================================================================
// tb_run_detector : four detector configurations driven in parallel, checked
//                   against a behavioural model through a scoreboard queue.
// Revision        : 1.0 - initial release
// ============================================================================
module tb_run_detector;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       w = 1'b0;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic [1:0] mode = 2'b00;

   logic       z0, z1, z2, z3, lw0, lw1, lw2, lw3;
   logic [1:0] rl0;
   logic [2:0] rl1;
   logic [1:0] rl2;
   logic [0:0] rl3;
   logic [7:0] mc0, mc1, mc2;
   logic [1:0] mc3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   run_detector #(.RUN_LEN(2), .CNT_W(8)) u_d0 (.clk(clk), .reset(reset), .w(w), .en(en),
      .mode(mode), .clr(clr), .z(z0), .last_w(lw0), .run_len(rl0), .match_count(mc0));
   run_detector #(.RUN_LEN(4), .CNT_W(8)) u_d1 (.clk(clk), .reset(reset), .w(w), .en(en),
      .mode(mode), .clr(clr), .z(z1), .last_w(lw1), .run_len(rl1), .match_count(mc1));
   run_detector #(.RUN_LEN(3), .CNT_W(8)) u_d2 (.clk(clk), .reset(reset), .w(w), .en(en),
      .mode(mode), .clr(clr), .z(z2), .last_w(lw2), .run_len(rl2), .match_count(mc2));
   run_detector #(.RUN_LEN(1), .CNT_W(2)) u_d3 (.clk(clk), .reset(reset), .w(w), .en(en),
      .mode(mode), .clr(clr), .z(z3), .last_w(lw3), .run_len(rl3), .match_count(mc3));

   int a_z[N], a_lw[N], a_rl[N], a_mc[N];
   always_comb begin
      a_z[0] = int'(z0);   a_z[1] = int'(z1);   a_z[2] = int'(z2);   a_z[3] = int'(z3);
      a_lw[0] = int'(lw0); a_lw[1] = int'(lw1); a_lw[2] = int'(lw2); a_lw[3] = int'(lw3);
      a_rl[0] = int'(rl0); a_rl[1] = int'(rl1); a_rl[2] = int'(rl2); a_rl[3] = int'(rl3);
      a_mc[0] = int'(mc0); a_mc[1] = int'(mc1); a_mc[2] = int'(mc2); a_mc[3] = int'(mc3);
   end

   function automatic int rlen(int i);
      case (i)
         0: return 2;
         1: return 4;
         2: return 3;
         default: return 1;
      endcase
   endfunction

   function automatic int cmax(int i);
      return (i == 3) ? 3 : 255;
   endfunction

   function automatic int qual(int md, int v);
      if (md == 1) return v;
      if (md == 2) return 1 - v;
      return 1;
   endfunction

   // Reference model state: length of the current run, its value, matches seen.
   int m_rl[N], m_lw[N], m_mc[N];

   typedef struct packed {
      logic [N-1:0]      z;
      logic [N-1:0]      lw;
      logic [N-1:0][7:0] rl;
      logic [N-1:0][7:0] mc;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string nm, input int i, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", nm, i, act, req, $time);
      end
   endtask

   function automatic int model_z(int i, int md);
      return (m_rl[i] == rlen(i) && qual(md, m_lw[i]) == 1) ? 1 : 0;
   endfunction

   function automatic exp_t snapshot(int md);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.z[i]  = 1'(model_z(i, md));
         e.lw[i] = 1'(m_lw[i]);
         e.rl[i] = 8'(m_rl[i]);
         e.mc[i] = 8'(m_mc[i]);
      end
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_rl[i] = 0;
         m_lw[i] = 0;
         m_mc[i] = 0;
      end
   endtask

   task automatic model_edge(input int wv, input int env, input int md, input int clrv);
      for (int i = 0; i < N; i++) begin
         if (env == 1) begin
            if (m_rl[i] == 0 || wv != m_lw[i]) begin
               m_rl[i] = 1;
               m_lw[i] = wv;
            end else if (m_rl[i] < rlen(i)) begin
               m_rl[i] = m_rl[i] + 1;
            end else if (md == 3) begin
               m_rl[i] = 1;
            end
         end
         if (clrv == 1) m_mc[i] = 0;
         else if (env == 1 && model_z(i, md) == 1 && m_mc[i] < cmax(i)) m_mc[i] = m_mc[i] + 1;
      end
   endtask

   // Inputs change mid-cycle; z must follow a mode change before any edge.
   task automatic step(input int wv, input int env, input int md, input int clrv);
      @(negedge clk);
      #1;
      reset = 1'b0;
      w     = 1'(wv);
      en    = 1'(env);
      mode  = 2'(md);
      clr   = 1'(clrv);
      #1;
      for (int i = 0; i < N; i++) chk("z_comb", i, a_z[i], model_z(i, md));
      model_edge(wv, env, md, clrv);
      sb.push_back(snapshot(md));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset = 1'b1;
      en    = 1'b0;
      clr   = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < N; i++) begin
         chk("reset_async_z", i, a_z[i], 0);
         chk("reset_async_run_len", i, a_rl[i], 0);
         chk("reset_async_last_w", i, a_lw[i], 0);
         chk("reset_async_count", i, a_mc[i], 0);
      end
      sb.push_back(snapshot(int'(mode)));
   endtask

   task automatic peek();
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < N; i++) begin
               chk("z", i, a_z[i], int'(e.z[i]));
               chk("last_w", i, a_lw[i], int'(e.lw[i]));
               chk("run_len", i, a_rl[i], int'(e.rl[i]));
               chk("match_count", i, a_mc[i], int'(e.mc[i]));
            end
         end
      end
   end

   initial begin : driver
      int seq1[6];
      int md;
      seq1 = '{0, 0, 1, 1, 1, 0};
      model_reset();

      do_reset();
      for (int k = 0; k < 6; k++) step(seq1[k], 1, 0, 0);
      peek();
      chk("t1_count", 0, a_mc[0], 3);
      chk("t1_z_end", 0, a_z[0], 0);

      do_reset();
      for (int k = 0; k < 9; k++) step(1, 1, 3, 0);
      peek();
      chk("t2_count", 1, a_mc[1], 2);
      chk("t2_run_len", 1, a_rl[1], 1);

      do_reset();
      for (int k = 0; k < 6; k++) step((k < 3) ? 0 : 1, 1, 1, 0);
      peek();
      chk("t3_z_ones", 2, a_z[2], 1);
      step(1, 0, 2, 0);
      chk("t3_mode_switch", 2, a_z[2], 0);

      do_reset();
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      for (int k = 0; k < 5; k++) step(k % 2, 0, 0, 0);
      step(1, 1, 0, 0);
      peek();
      chk("t4_z_hold", 2, a_z[2], 1);
      chk("t4_run_len", 2, a_rl[2], 3);

      do_reset();
      for (int k = 0; k < 6; k++) step(int'($urandom_range(0, 1)), 1, 0, 0);
      peek();
      chk("t5_saturate", 3, a_mc[3], 3);
      step(1, 1, 0, 1);
      peek();
      chk("t5_clear", 3, a_mc[3], 0);
      chk("t5_z", 3, a_z[3], 1);

      do_reset();
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      peek();
      chk("t6_pre_run_len", 0, a_rl[0], 2);
      do_reset();
      step(1, 1, 0, 0);
      peek();
      chk("t6_run_len", 0, a_rl[0], 1);
      chk("t6_last_w", 0, a_lw[0], 1);

      do_reset();
      md = 0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 99) < 10) md = int'($urandom_range(0, 3));
         if ($urandom_range(0, 99) < 2) do_reset();
         else step(int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1 : 0,
                   md, ($urandom_range(0, 19) == 0) ? 1 : 0);
      end

      for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
      #1;
      chk("scoreboard_drain", 0, sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/run_detector.md
# run_detector

Parametrised serial run detector: samples a 1-bit input `w` on enabled clocks and asserts Moore output `z` once the last `RUN_LEN` samples are identical. It supports polarity modes, overlapping and non-overlapping detection, a saturating match counter and a visible run-length state. It replaces the fixed-length one-hot/binary detector FSM pair at the board top level. Switch, button and LED mapping stays in `top`.

## Interface
Parameters:
- `RUN_LEN`, default 2: number of consecutive identical samples that constitutes a match. Legal range is 1..255.
- `CNT_W`, default 8: width of the match counter.
- `ST_W`, default `$clog2(RUN_LEN+1)`: width of the run-length state output. This is derived and must not be overridden.

Ports:
- `clk` in 1: sample clock.
- `reset` in 1: asynchronous, active-high reset.
- `w` in 1: serial data input.
- `en` in 1: sample enable. State updates only on rising edges of `clk` where `en`=1.
- `mode` in 2: detection mode.
  - 00: either polarity, overlapping.
  - 01: runs of 1s only.
  - 10: runs of 0s only.
  - 11: either polarity, non-overlapping.
- `clr` in 1: synchronous clear of `match_count`.
- `z` out 1: match flag. Moore output, combinational from registered state and `mode`.
- `last_w` out 1: value of the current run.
- `run_len` out `ST_W`: current run length, 0..`RUN_LEN`.
- `match_count` out `CNT_W`: number of matched samples, saturating.

## Operation
- State consists of `run_len` (counter), `last_w`, and `match_count`.
- Reset values: `run_len`=0, `last_w`=0, `match_count`=0. This forces `z`=0.
- `run_len`=0 is the idle state: no sample has been taken since reset.
- On an enabled edge:
  - If `run_len`=0, load `run_len`=1 and `last_w`=`w`.
  - Else if `w`≠`last_w`, load `run_len`=1 and `last_w`=`w`.
  - Else if `w`=`last_w` and `run_len`<`RUN_LEN`, increment `run_len`.
  - Else if `w`=`last_w` and `run_len`=`RUN_LEN`:
    - modes 00, 01, 10: hold at `RUN_LEN` (saturate, overlapping).
    - mode 11: load `run_len`=1 (restart the run).
- `z` = (`run_len`==`RUN_LEN`) AND qualifier, where the qualifier is:
  - modes 00 and 11: 1.
  - mode 01: `last_w`.
  - mode 10: ~`last_w`.
- `match_count`:
  - On an enabled edge whose next state yields `z`=1 under the current `mode`, increment by 1.
  - Saturate at 2^`CNT_W`−1, with no wrap.
- `clr`=1 on any edge loads `match_count`=0 and overrides a simultaneous increment. `clr` does not affect `run_len` or `last_w`.
- `en`=0: all state holds. `clr` still acts.
- A `mode` change takes effect on `z` immediately and combinationally. State is not modified. The non-overlap restart applies only on edges where `mode`=11.
- `RUN_LEN`=1: every enabled sample gives `run_len`=1, so `z`=1 whenever the polarity qualifies.

## Timing
- All state changes occur on the rising edge of `clk`. `reset` clears state asynchronously on assertion, with no clock required. Release is synchronous to the next edge.
- Detection latency: `z` rises in the cycle after the edge that captures the `RUN_LEN`-th identical sample. There are zero extra pipeline stages.
- `z` in mode 11: high for exactly one enabled-sample interval per `RUN_LEN` identical samples.
- `match_count` updates on the same edge that makes `z` rise. The counter and `z` are never skewed.
- Reset mid-run: all outputs return to their reset values within the same cycle. The first post-reset sample starts a fresh run and does not inherit the prior `last_w`.
- `en` low for any number of cycles between samples does not break a run.

## Test plan
- Test 1, `RUN_LEN`=2, mode 00, `en`=1:
  - Stimulus: `w`=0,0,1,1,1,0.
  - Required `z` after each edge: 0,1,0,1,1,0.
  - Required `match_count` end value: 3.
- Test 2, `RUN_LEN`=4, mode 11:
  - Stimulus: `w`=1 for 9 samples.
  - Required `z` high only after samples 4 and 8.
  - Required `run_len` sequence: 1,2,3,4,1,2,3,4,1.
  - Required `match_count`: 2.
- Test 3, `RUN_LEN`=3, mode 01:
  - Stimulus: `w`=0,0,0,1,1,1.
  - Required `z` stays 0 through sample 3 and is 1 after sample 6.
  - Switching `mode` to 10 then drops `z` to 0 in the same cycle.
- Test 4, `RUN_LEN`=3:
  - Stimulus: `w`=1,1 with `en`=1, then `en`=0 for 5 cycles while `w` toggles, then `w`=1 with `en`=1.
  - Required `z`=1, because the run holds across the idle cycles.
- Test 5, `CNT_W`=2, `RUN_LEN`=1, mode 00:
  - Stimulus: 6 samples.
  - Required `match_count` saturates at 3.
  - Then `clr` together with a matching sample gives `match_count`=0.
- Test 6, reset:
  - Stimulus: assert `reset` between edges mid-run with `run_len`=2.
  - Required `z`, `run_len`, `last_w` and `match_count` read 0 before the next edge.
  - Next sample `w`=1 gives `run_len`=1 and `last_w`=1.
